mem_access_ctrl: RTL and testbench

Sequencer between the multi-cycle CPU datapath and the single-port data RAM. The RAM has a 12-bit word address, a 1-bit write enable, 32-bit data and a registered read output with 1-cycle latency.
- Converts CPU byte-addressed load/store requests (byte, half, word) into RAM word accesses.
- Sub-word stores use read-modify-write.
- Loads are lane-extracted with optional sign extension.
- Raises a one-cycle ready pulse when the access completes.

---
 rtl/mem_access_pkg.sv | 10 +
 rtl/mem_access_lane.sv | 25 ++
 rtl/mem_access_ctrl.sv | 108 ++++++++++
 tb/tb_mem_access_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// mem_access_pkg: size encodings, lane-offset width and sequencer states for mem_access_ctrl.
package mem_access_pkg;
    localparam int OFF_W = 2;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    typedef enum logic [2:0] {
        IDLE, RD_ISSUE, RD_DATA, RMW_RD, RMW_MERGE, WR, ERR, DONE
    } state_e;
endpackage

// File: rtl/mem_access_lane.sv
// mem_access_lane: big-endian lane extract/extend for loads and lane merge for sub-word stores.
module mem_access_lane
    import mem_access_pkg::*;
(
    input  logic [31:0]      word,
    input  logic [OFF_W-1:0] offset,
    input  logic [1:0]       size,
    input  logic             sign_ext,
    input  logic [31:0]      wdata,
    output logic [31:0]      load_val,
    output logic [31:0]      merged
);
    logic [4:0]  sh;
    logic [15:0] lane;
    logic [31:0] mask;
    always_comb begin
        // offset 0 is the most significant lane, so the shift counts down from the top
        sh = size == SZ_BYTE ? {~offset, 3'b000} : size == SZ_HALF ? {~offset[1], 4'b0000} : 5'd0;
        lane = 16'(word >> sh);
        mask = size == SZ_BYTE ? 32'hFF << sh : size == SZ_HALF ? 32'hFFFF << sh : '1;
        load_val = size == SZ_BYTE ? {{24{sign_ext & lane[7]}}, lane[7:0]} :
                   size == SZ_HALF ? {{16{sign_ext & lane[15]}}, lane[15:0]} : word;
        merged = (word & ~mask) | ((wdata << sh) & mask);
    end
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences CPU byte/half/word loads and stores onto a single-port word RAM.
// MEM_ACCESS_ALIGN_CHECK_EN enables the misalignment error path; otherwise offending low bits are cleared.
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [31:0]       addr,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              ready,
    output logic              addr_err,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_din,
    input  logic [31:0]       ram_dout
);
    state_e            state_q, state_d;
    logic [ADDR_W+1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic              sign_q, sign_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [31:0]       load_val, merged;
    logic [1:0]        low_clr;
    logic              misal;
    logic              unused_addr_hi;

    assign unused_addr_hi = ^addr[31:ADDR_W+2];
    assign low_clr = size == SZ_HALF ? 2'b01 : size[1] ? 2'b11 : 2'b00;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    assign misal    = |(addr[1:0] & low_clr);
    assign addr_err = state_q == ERR;
`else
    assign misal    = 1'b0;
    assign addr_err = 1'b0;
`endif
    assign ready    = state_q == DONE || state_q == ERR;
    assign ram_we   = state_q == WR;
    assign ram_addr = addr_q[ADDR_W+1:2];
    assign ram_din  = wdata_q;
    assign rdata    = rdata_q;

    mem_access_lane u_lane (
        .word     (ram_dout),
        .offset   (addr_q[1:0]),
        .size     (size_q),
        .sign_ext (sign_q),
        .wdata    (wdata_q),
        .load_val (load_val),
        .merged   (merged)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        size_d  = size_q;
        sign_d  = sign_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: if (req) begin
                addr_d  = {addr[ADDR_W+1:2], addr[1:0] & ~low_clr};
                size_d  = size;
                sign_d  = sign_ext;
                wdata_d = wdata;
                state_d = misal ? ERR : !we ? RD_ISSUE : size[1] ? WR : RMW_RD;
            end
            RD_ISSUE: state_d = RD_DATA;
            RD_DATA: begin
                rdata_d = load_val;
                state_d = DONE;
            end
            RMW_RD: state_d = RMW_MERGE;
            // the merged word reuses the store-data register as the write word
            RMW_MERGE: begin
                wdata_d = merged;
                state_d = WR;
            end
            WR: state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            size_q  <= SZ_BYTE;
            sign_q  <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            sign_q  <= sign_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed and random accesses against a byte-level memory model and a RAM model.
// Expectations follow MEM_ACCESS_ALIGN_CHECK_EN the same way the design does.
module tb_mem_access_ctrl;
    logic        clk = 1'b0;
    logic        rst, req, we, sign_ext, ready, addr_err, ram_we;
    logic [1:0]  size;
    logic [31:0] addr, wdata, rdata, ram_din, ram_dout;
    logic [11:0] ram_addr;
    logic        bd_we;
    logic [11:0] bd_addr;
    logic [31:0] bd_data;
    logic [31:0] mem [0:4095];
    logic [31:0] refm [0:15];
    logic [31:0] exp_rdata, rmask, ra, pv;
    int          checks = 0, failures = 0, rst_we, rst_rdy;

    always #5 clk = ~clk;

    mem_access_ctrl #(.ADDR_W(12)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .size(size),
        .sign_ext(sign_ext), .wdata(wdata), .rdata(rdata), .ready(ready),
        .addr_err(addr_err), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        else if (bd_we) mem[bd_addr] <= bd_data;
        ram_dout <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic is_mis(input logic [31:0] a, input logic [1:0] sz);
        return sz == 2'd1 ? a[0] : sz[1] ? (a[1:0] != 2'b00) : 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] w, input int off, input logic [1:0] sz, input logic sx);
        logic [7:0]  b [4];
        logic [15:0] h;
        for (int i = 0; i < 4; i++) b[i] = w[31-8*i -: 8];
        h = {b[off], (off < 3) ? b[off+1] : 8'h00};
        if (sz == 2'd0) return sx ? {{24{b[off][7]}}, b[off]} : {24'h0, b[off]};
        if (sz == 2'd1) return sx ? {{16{h[15]}}, h} : {16'h0, h};
        return w;
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] w, input int off, input logic [1:0] sz, input logic [31:0] d);
        logic [7:0] b [4];
        if (sz[1]) return d;
        for (int i = 0; i < 4; i++) b[i] = w[31-8*i -: 8];
        if (sz == 2'd0) b[off] = d[7:0];
        else begin
            b[off]   = d[15:8];
            b[off+1] = d[7:0];
        end
        return {b[0], b[1], b[2], b[3]};
    endfunction

    task automatic access(input string tag, input logic w, input logic [31:0] a, input logic [1:0] sz,
                          input logic sx, input logic [31:0] wd);
        int off, wi, lat, we_cnt, we_at, exp_lat;
        logic exp_err, err_seen;
        logic [11:0] waddr;
        wi = int'(a[5:2]);
        off = int'(a[1:0]);
        exp_err = 1'b0;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
        exp_err = is_mis(a, sz);
`endif
        if (sz == 2'd1) off = off & 2;
        else if (sz[1]) off = 0;
        if (exp_err) exp_lat = 1;
        else if (!w) begin
            exp_lat = 3;
            exp_rdata = model_load(refm[wi], off, sz, sx);
        end else begin
            exp_lat = sz[1] ? 2 : 4;
            refm[wi] = model_store(refm[wi], off, sz, wd);
        end
        req = 1'b1; we = w; addr = a; size = sz; sign_ext = sx; wdata = wd;
        lat = 0; we_cnt = 0; we_at = 0; waddr = '0; err_seen = 1'b0;
        for (int n = 1; n <= 8 && lat == 0; n++) begin
            @(posedge clk); #1;
            req = 1'b0;
            if (ram_we) begin
                we_cnt++;
                we_at = n;
                waddr = ram_addr;
            end
            if (ready) begin
                lat = n;
                err_seen = addr_err;
            end
        end
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_err"}, {31'b0, err_seen}, {31'b0, exp_err});
        chk({tag, "_we"}, we_cnt, (w && !exp_err) ? 1 : 0);
        if (w && !exp_err) begin
            chk({tag, "_wcyc"}, we_at, exp_lat - 1);
            chk({tag, "_waddr"}, {20'b0, waddr}, {20'b0, a[13:2]});
        end
        chk({tag, "_rdata"}, rdata, exp_rdata);
        chk({tag, "_mem"}, mem[wi], refm[wi]);
        @(posedge clk); #1;
        chk({tag, "_pulse"}, {31'b0, ready}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; size = '0; sign_ext = 1'b0; wdata = '0;
        bd_we = 1'b0; bd_addr = '0; bd_data = '0; exp_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'b0, ready}, 32'd0);
        chk("rst_err", {31'b0, addr_err}, 32'd0);
        chk("rst_ramwe", {31'b0, ram_we}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_ramaddr", {20'b0, ram_addr}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            pv = $urandom;
            if (i == 8) pv = 32'h11223344;
            if (i == 12) pv = 32'h80FF7F01;
            bd_we = 1'b1; bd_addr = 12'(i); bd_data = pv; refm[i] = pv;
            @(posedge clk); #1;
        end
        bd_we = 1'b0;

        access("wst", 1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF);
        access("wld", 1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
        chk("wld_val", rdata, 32'hDEADBEEF);
        access("bst", 1'b1, 32'h21, 2'd0, 1'b0, 32'h000000AA);
        chk("bst_word", mem[8], 32'h11AA3344);
        access("lbs", 1'b0, 32'h30, 2'd0, 1'b1, 32'h0);
        chk("lbs_val", rdata, 32'hFFFFFF80);
        access("lbu", 1'b0, 32'h30, 2'd0, 1'b0, 32'h0);
        chk("lbu_val", rdata, 32'h00000080);
        access("lhs", 1'b0, 32'h32, 2'd1, 1'b1, 32'h0);
        chk("lhs_val", rdata, 32'h00007F01);
        access("lhm", 1'b0, 32'h31, 2'd1, 1'b0, 32'h0);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
        chk("lhm_val", rdata, 32'h00007F01);
`else
        chk("lhm_val", rdata, 32'h000080FF);
`endif

        rst_we = 0; rst_rdy = 0;
        req = 1'b1; we = 1'b1; addr = 32'h22; size = 2'd0; sign_ext = 1'b0; wdata = 32'h55;
        @(posedge clk); #1;
        req = 1'b0;
        rst_we += int'(ram_we); rst_rdy += int'(ready);
        @(posedge clk); #1;
        rst_we += int'(ram_we); rst_rdy += int'(ready);
        rst = 1'b1;
        exp_rdata = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        rst_we += int'(ram_we); rst_rdy += int'(ready);
        repeat (4) begin
            @(posedge clk); #1;
            rst_we += int'(ram_we); rst_rdy += int'(ready);
        end
        chk("rmwrst_we", rst_we, 0);
        chk("rmwrst_ready", rst_rdy, 0);
        chk("rmwrst_mem", mem[8], 32'h11AA3344);
        chk("rmwrst_rdata", rdata, 32'h0);
        access("rmwrst_ld", 1'b0, 32'h20, 2'd2, 1'b0, 32'h0);
        chk("rmwrst_ldval", rdata, 32'h11AA3344);

        rmask = '0;
        req = 1'b1; we = 1'b0; addr = 32'h30; size = 2'd2; sign_ext = 1'b0;
        for (int n = 1; n <= 16; n++) begin
            @(posedge clk); #1;
            if (n == 11) req = 1'b0;
            if (ready) begin
                rmask[n] = 1'b1;
                chk("b2b_rdata", rdata, 32'h80FF7F01);
            end
        end
        chk("b2b_mask", rmask, 32'h00000888);
        exp_rdata = 32'h80FF7F01;

        for (int k = 0; k < 80; k++) begin
            ra = $urandom;
            ra[13:6] = '0;
            access("rnd", 1'($urandom_range(0, 1)), ra, 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
